cp0_exception_sequencer: RTL and testbench

- Front-end controller for the CP0 exception path.
- Each cycle it arbitrates synchronous exception requests from four pipeline stages (F, D, E, M), unmasked hardware interrupts, and ERET.
- It generates the single-cycle write strobes (exception_abort / irq) that load the BadVInstr, EPC and Cause registers, holding the captured data stable while the strobe is high.
- It then sequences the pipeline flush and the PC redirect.

---
 rtl/cp0_exception_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cp0_exception_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_sequencer.sv
// ============================================================================
// cp0_exception_sequencer
//   Arbitrates stage exceptions, interrupts and ERET for CP0, then sequences
//   the capture strobe, pipeline flush and fetch redirect.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module cp0_exception_sequencer #(
  parameter int          FLUSH_CYCLES = 3,
  parameter logic [31:0] VECTOR       = 32'hBFC00380,
  parameter int          INT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ex_req,
  input  logic [19:0]      ex_code,
  input  logic [127:0]     ex_pc,
  input  logic [127:0]     ex_instr,
  input  logic [INT_W-1:0] int_pending,
  input  logic [INT_W-1:0] int_mask,
  input  logic             status_ie,
  input  logic             status_exl,
  input  logic             eret,
  input  logic [31:0]      epc_in,
  output logic             exception_abort,
  output logic             irq,
  output logic [31:0]      badvinstr_p,
  output logic [31:0]      epc_p,
  output logic [4:0]       exc_code,
  output logic             exl_set,
  output logic             exl_clr,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STROBE   = 2'd1,
    S_FLUSH    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;

  logic        w_int_take;
  logic        w_exc_any;
  logic [31:0] w_sel_instr;
  logic [31:0] w_sel_pc;
  logic [4:0]  w_sel_code;

  assign w_int_take = (|(int_pending & int_mask)) & status_ie & ~status_exl;
  assign w_exc_any  = |ex_req;

  // Oldest stage (M) has highest priority.
  always_comb begin
    w_sel_instr = ex_instr[31:0];
    w_sel_pc    = ex_pc[31:0];
    w_sel_code  = ex_code[4:0];
    if (ex_req[3]) begin
      w_sel_instr = ex_instr[127:96];
      w_sel_pc    = ex_pc[127:96];
      w_sel_code  = ex_code[19:15];
    end else if (ex_req[2]) begin
      w_sel_instr = ex_instr[95:64];
      w_sel_pc    = ex_pc[95:64];
      w_sel_code  = ex_code[14:10];
    end else if (ex_req[1]) begin
      w_sel_instr = ex_instr[63:32];
      w_sel_pc    = ex_pc[63:32];
      w_sel_code  = ex_code[9:5];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= 4'd0;
      exception_abort <= 1'b0;
      irq             <= 1'b0;
      badvinstr_p     <= 32'd0;
      epc_p           <= 32'd0;
      exc_code        <= 5'd0;
      exl_set         <= 1'b0;
      exl_clr         <= 1'b0;
      flush           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= 32'd0;
      busy            <= 1'b0;
    end else begin
      exception_abort <= 1'b0;
      irq             <= 1'b0;
      exl_set         <= 1'b0;
      exl_clr         <= 1'b0;
      redirect_valid  <= 1'b0;
      flush           <= 1'b0;

      case (state_q)
        S_STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q        <= S_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= VECTOR;
          end else begin
            state_q <= S_FLUSH;
            flush   <= 1'b1;
          end
        end

        S_FLUSH: begin
          if (cnt_q == 4'd1) begin
            state_q        <= S_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= VECTOR;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            flush <= 1'b1;
          end
        end

        // The redirect cycle doubles as an acceptance cycle, like IDLE.
        S_IDLE, S_REDIRECT: begin
          if (w_exc_any) begin
            state_q         <= S_STROBE;
            badvinstr_p     <= w_sel_instr;
            epc_p           <= w_sel_pc;
            exc_code        <= w_sel_code;
            exception_abort <= 1'b1;
            exl_set         <= 1'b1;
            flush           <= 1'b1;
            busy            <= 1'b1;
            cnt_q           <= CNT_LOAD;
          end else if (w_int_take) begin
            state_q     <= S_STROBE;
            badvinstr_p <= ex_instr[127:96];
            epc_p       <= ex_pc[127:96];
            exc_code    <= 5'd0;
            irq         <= 1'b1;
            exl_set     <= 1'b1;
            flush       <= 1'b1;
            busy        <= 1'b1;
            cnt_q       <= CNT_LOAD;
          end else if (eret) begin
            state_q        <= S_IDLE;
            exl_clr        <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= epc_in;
            flush          <= 1'b1;
            busy           <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0_exception_sequencer.sv
// ============================================================================
// tb_cp0_exception_sequencer
//   Directed checks of the CP0 exception sequencer (default and 1-cycle flush).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cp0_exception_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   ex_req;
  logic [19:0]  ex_code;
  logic [127:0] ex_pc;
  logic [127:0] ex_instr;
  logic [5:0]   int_pending;
  logic [5:0]   int_mask;
  logic         status_ie;
  logic         status_exl;
  logic         eret;
  logic [31:0]  epc_in;

  logic         exception_abort, irq, exl_set, exl_clr, flush, redirect_valid, busy;
  logic [31:0]  badvinstr_p, epc_p, redirect_pc;
  logic [4:0]   exc_code;

  logic         f1_abort, f1_irq, f1_exl_set, f1_exl_clr, f1_flush, f1_rv, f1_busy;
  logic [31:0]  f1_badv, f1_epc, f1_rpc;
  logic [4:0]   f1_code;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cp0_exception_sequencer dut (
    .clk(clk), .rst(rst), .ex_req(ex_req), .ex_code(ex_code), .ex_pc(ex_pc),
    .ex_instr(ex_instr), .int_pending(int_pending), .int_mask(int_mask),
    .status_ie(status_ie), .status_exl(status_exl), .eret(eret), .epc_in(epc_in),
    .exception_abort(exception_abort), .irq(irq), .badvinstr_p(badvinstr_p),
    .epc_p(epc_p), .exc_code(exc_code), .exl_set(exl_set), .exl_clr(exl_clr),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  cp0_exception_sequencer #(.FLUSH_CYCLES(1)) dut_f1 (
    .clk(clk), .rst(rst), .ex_req(ex_req), .ex_code(ex_code), .ex_pc(ex_pc),
    .ex_instr(ex_instr), .int_pending(int_pending), .int_mask(int_mask),
    .status_ie(status_ie), .status_exl(status_exl), .eret(eret), .epc_in(epc_in),
    .exception_abort(f1_abort), .irq(f1_irq), .badvinstr_p(f1_badv),
    .epc_p(f1_epc), .exc_code(f1_code), .exl_set(f1_exl_set), .exl_clr(f1_exl_clr),
    .flush(f1_flush), .redirect_valid(f1_rv), .redirect_pc(f1_rpc),
    .busy(f1_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then stable for inspection.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    ex_req      = 4'd0;
    int_pending = 6'd0;
    int_mask    = 6'd0;
    status_ie   = 1'b0;
    status_exl  = 1'b0;
    eret        = 1'b0;
  endtask

  function automatic logic [6:0] pulses();
    return {exception_abort, irq, exl_set, exl_clr, flush, redirect_valid, busy};
  endfunction

  initial begin
    rst      = 1'b1;
    clear_req();
    ex_req   = 4'hF;
    ex_code  = 20'd0;
    ex_pc    = 128'd0;
    ex_instr = 128'd0;
    epc_in   = 32'd0;

    // Reset, with all stage requests raised
    ex_instr = {32'hFFFF0003, 32'hFFFF0002, 32'hFFFF0001, 32'hFFFF0000};
    ex_pc    = {32'h0000F003, 32'h0000F002, 32'h0000F001, 32'h0000F000};
    ex_code  = {5'd3, 5'd2, 5'd1, 5'd31};
    step();
    step();
    check("rst_pulses", {25'd0, pulses()}, 32'd0);
    check("rst_badv", badvinstr_p, 32'd0);
    check("rst_epc", epc_p, 32'd0);
    check("rst_code", {27'd0, exc_code}, 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    ex_req = 4'd0;
    rst    = 1'b0;
    step();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single E-stage exception; dut_f1 runs the 1-cycle flush variant alongside
    ex_req   = 4'b0100;
    ex_instr = {32'h11110003, 32'h8C220004, 32'h11110001, 32'h11110000};
    ex_pc    = {32'h80000F0C, 32'h80001010, 32'h80000F04, 32'h80000F00};
    ex_code  = {5'd9, 5'd4, 5'd7, 5'd6};
    step();
    ex_req = 4'd0;
    check("e_abort", {31'd0, exception_abort}, 32'd1);
    check("e_irq1", {31'd0, irq}, 32'd0);
    check("e_badv", badvinstr_p, 32'h8C220004);
    check("e_epc", epc_p, 32'h80001010);
    check("e_code", {27'd0, exc_code}, 32'd4);
    check("e_exlset", {31'd0, exl_set}, 32'd1);
    check("e_flush1", {31'd0, flush}, 32'd1);
    check("e_busy1", {31'd0, busy}, 32'd1);
    check("f1_abort", {31'd0, f1_abort}, 32'd1);
    check("f1_flush1", {31'd0, f1_flush}, 32'd1);
    step();
    check("e_flush2", {31'd0, flush}, 32'd1);
    check("e_abort2", {31'd0, exception_abort}, 32'd0);
    check("e_exlset2", {31'd0, exl_set}, 32'd0);
    check("e_irq2", {31'd0, irq}, 32'd0);
    check("f1_rv", {31'd0, f1_rv}, 32'd1);
    check("f1_rpc", f1_rpc, 32'hBFC00380);
    check("f1_flush2", {31'd0, f1_flush}, 32'd0);
    step();
    check("e_flush3", {31'd0, flush}, 32'd1);
    check("e_rv3", {31'd0, redirect_valid}, 32'd0);
    step();
    check("e_rv4", {31'd0, redirect_valid}, 32'd1);
    check("e_rpc4", redirect_pc, 32'hBFC00380);
    check("e_flush4", {31'd0, flush}, 32'd0);
    check("e_irq4", {31'd0, irq}, 32'd0);
    step();
    check("e_idle", {25'd0, pulses()}, 32'd0);
    check("e_hold_badv", badvinstr_p, 32'h8C220004);

    // Priority: M beats D, F and a live interrupt
    ex_req      = 4'b1011;
    ex_instr    = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
    ex_pc       = {32'h80004003, 32'h80004002, 32'h80004001, 32'h80004000};
    ex_code     = {5'd13, 5'd12, 5'd11, 5'd10};
    int_pending = 6'b000001;
    int_mask    = 6'b000001;
    status_ie   = 1'b1;
    step();
    clear_req();
    check("m_abort", {31'd0, exception_abort}, 32'd1);
    check("m_code", {27'd0, exc_code}, 32'd13);
    check("m_badv", badvinstr_p, 32'hDEAD0003);
    check("m_epc", epc_p, 32'h80004003);
    for (int i = 0; i < 4; i++) begin
      check("m_no_irq", {31'd0, irq}, 32'd0);
      step();
    end
    check("m_idle", {31'd0, busy}, 32'd0);

    // Interrupt only
    ex_instr    = {32'h12345678, 96'd0};
    ex_pc       = {32'h80003000, 96'd0};
    int_pending = 6'b000100;
    int_mask    = 6'b000100;
    status_ie   = 1'b1;
    step();
    clear_req();
    check("i_irq", {31'd0, irq}, 32'd1);
    check("i_abort", {31'd0, exception_abort}, 32'd0);
    check("i_code", {27'd0, exc_code}, 32'd0);
    check("i_badv", badvinstr_p, 32'h12345678);
    check("i_epc", epc_p, 32'h80003000);
    check("i_exlset", {31'd0, exl_set}, 32'd1);
    step(); step(); step(); step();
    check("i_idle", {31'd0, busy}, 32'd0);

    // Interrupt blocked by EXL
    int_pending = 6'b000100;
    int_mask    = 6'b000100;
    status_ie   = 1'b1;
    status_exl  = 1'b1;
    step();
    clear_req();
    check("x_pulses", {25'd0, pulses()}, 32'd0);

    // ERET alone
    eret   = 1'b1;
    epc_in = 32'h80002000;
    step();
    eret = 1'b0;
    check("r_exlclr", {31'd0, exl_clr}, 32'd1);
    check("r_rv", {31'd0, redirect_valid}, 32'd1);
    check("r_rpc", redirect_pc, 32'h80002000);
    check("r_flush", {31'd0, flush}, 32'd1);
    check("r_busy", {31'd0, busy}, 32'd0);
    check("r_exlset", {31'd0, exl_set}, 32'd0);
    step();
    check("r_after", {25'd0, pulses()}, 32'd0);

    // ERET loses to an F-stage exception
    eret     = 1'b1;
    ex_req   = 4'b0001;
    ex_code  = {5'd13, 5'd12, 5'd11, 5'd10};
    ex_instr = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
    step();
    clear_req();
    check("rf_abort", {31'd0, exception_abort}, 32'd1);
    check("rf_exlclr", {31'd0, exl_clr}, 32'd0);
    check("rf_code", {27'd0, exc_code}, 32'd10);
    check("rf_badv", badvinstr_p, 32'hDEAD0000);
    step(); step(); step(); step();

    // Busy blocking, then back-to-back acceptance on the redirect cycle
    ex_req = 4'b0100;
    step();
    ex_req = 4'd0;
    step();
    ex_req = 4'b1000;
    step();
    ex_req = 4'd0;
    check("b_ignored", {31'd0, exception_abort}, 32'd0);
    check("b_code_held", {27'd0, exc_code}, 32'd12);
    ex_req = 4'b1000;
    step();
    check("b_rv", {31'd0, redirect_valid}, 32'd1);
    check("b_abort_rv", {31'd0, exception_abort}, 32'd0);
    step();
    ex_req = 4'd0;
    check("b_abort2", {31'd0, exception_abort}, 32'd1);
    check("b_code2", {27'd0, exc_code}, 32'd13);
    step(); step(); step(); step();
    check("b_idle", {31'd0, busy}, 32'd0);

    // Reset in the second FLUSH cycle
    ex_req = 4'b0010;
    step();
    ex_req = 4'd0;
    step();
    step();
    check("z_flush_pre", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("z_busy", {31'd0, busy}, 32'd0);
    check("z_flush", {31'd0, flush}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("z_no_rv", {31'd0, redirect_valid}, 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
